// File: rtl/music_sequencer.sv
// Song ROM sequencer: steps the ROM address at a fixed tempo and hands each
// fetched note to the tone generator, with pause, restart, loop and end-code.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for play, outputs held
// S_FETCH | address stable, ROM registering it
// S_WAIT  | ROM data arrives; sampled on exit
// S_PLAY  | note held for TICKS_PER_BEAT cycles, frozen while play=0
// S_DONE  | song finished, silent until restart or reset
module music_sequencer #(
  parameter int          TICKS_PER_BEAT = 12_500_000,
  parameter int          SONG_LEN       = 200,
  parameter logic [7:0]  END_CODE       = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       restart,
  input  logic       loop_en,
  input  logic [7:0] note_in,
  output logic [7:0] address,
  output logic [7:0] note_out,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(TICKS_PER_BEAT - 1);
  localparam logic [7:0]       ADDR_LAST = 8'(SONG_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [7:0]       note_hold;
  logic             beat_last;
  logic             end_hit;

  assign beat_last = (beat_cnt == BEAT_LAST);

  // End of song: terminator read from ROM, or last beat of the last address.
  assign end_hit = ((state == S_WAIT) && (note_in == END_CODE)) ||
                   ((state == S_PLAY) && play && beat_last && (address == ADDR_LAST));

  assign busy = (state == S_FETCH) || (state == S_WAIT) || (state == S_PLAY);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      address    <= 8'd0;
      note_out   <= 8'd0;
      note_hold  <= 8'd0;
      note_valid <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      note_valid <= 1'b0;
      if (restart) begin
        address  <= 8'd0;
        beat_cnt <= '0;
        note_out <= 8'd0;
        state    <= play ? S_FETCH : S_IDLE;
      end else if (end_hit) begin
        if (loop_en) begin
          address <= 8'd0;
          state   <= S_FETCH;
        end else begin
          note_out <= 8'd0;
          state    <= S_DONE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (play) state <= S_FETCH;
          end
          S_FETCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            note_hold  <= note_in;
            note_out   <= note_in;
            note_valid <= 1'b1;
            beat_cnt   <= '0;
            state      <= S_PLAY;
          end
          S_PLAY: begin
            // Pause silences the output but keeps the note for resume.
            if (!play) begin
              note_out <= 8'd0;
            end else begin
              note_out <= note_hold;
              if (beat_last) begin
                address <= address + 8'd1;
                state   <= S_FETCH;
              end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
              end
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a registered behavioural ROM
// (entry = address+1) and a note scoreboard popped on every note_valid.
module tb_music_sequencer;

  logic       clk;
  logic       rst_n;
  logic       play;
  logic       restart;
  logic       loop_en;
  logic [7:0] note_in;
  logic [7:0] address;
  logic [7:0] note_out;
  logic       note_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom [0:255];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  music_sequencer #(
    .TICKS_PER_BEAT(4),
    .SONG_LEN      (8),
    .END_CODE      (8'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play      (play),
    .restart   (restart),
    .loop_en   (loop_en),
    .note_in   (note_in),
    .address   (address),
    .note_out  (note_out),
    .note_valid(note_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) note_in <= rom[address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", {24'd0, note_out}, 32'hDEAD);
    end else begin
      e = exp_q.pop_front();
      chk("sb_note", {24'd0, note_out}, {24'd0, e});
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (note_valid === 1'b1) sb_check();
    end
  endtask

  task automatic push_seq(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q.push_back(8'(v));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 1);
    rst_n   = 1'b0;
    play    = 1'b1;
    restart = 1'b0;
    loop_en = 1'b0;

    // Reset held for three edges with play asserted
    for (int i = 0; i < 3; i++) begin
      steps(1);
      chk("rst_outputs", {13'd0, address, note_out, note_valid, busy, done}, 32'd0);
    end
    rst_n = 1'b1;

    // Normal play, loop off, all eight notes
    push_seq(1, 8);
    steps(1);
    chk("e1_busy", {31'd0, busy}, 32'd1);
    chk("e1_note", {24'd0, note_out}, 32'd0);
    steps(2);
    chk("e3_note", {24'd0, note_out}, 32'd1);
    chk("e3_valid", {31'd0, note_valid}, 32'd1);
    chk("e3_addr", {24'd0, address}, 32'd0);
    steps(1);
    chk("e4_valid", {31'd0, note_valid}, 32'd0);
    steps(3);
    chk("e7_addr", {24'd0, address}, 32'd1);
    chk("e7_note", {24'd0, note_out}, 32'd1);
    steps(2);
    chk("e9_note", {24'd0, note_out}, 32'd2);
    chk("e9_valid", {31'd0, note_valid}, 32'd1);
    steps(39);
    chk("e48_note", {24'd0, note_out}, 32'd8);
    chk("e48_addr", {24'd0, address}, 32'd7);
    steps(1);
    chk("end_note", {24'd0, note_out}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      steps(1);
      chk("done_hold", {13'd0, address, note_out, note_valid, busy, done},
          {13'd0, 8'd7, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    chk("sb_drain_a", exp_q.size(), 32'd0);

    // Restart from DONE with play low lands in IDLE
    restart = 1'b1;
    play    = 1'b0;
    steps(1);
    restart = 1'b0;
    chk("rs_done_done", {31'd0, done}, 32'd0);
    chk("rs_done_addr", {24'd0, address}, 32'd0);
    chk("rs_done_busy", {31'd0, busy}, 32'd0);
    chk("rs_done_note", {24'd0, note_out}, 32'd0);

    // Terminator at entry 3 with looping
    rom[3]  = 8'hFF;
    loop_en = 1'b1;
    play    = 1'b1;
    push_seq(1, 3);
    push_seq(1, 2);
    steps(15);
    chk("t4_note3", {24'd0, note_out}, 32'd3);
    steps(4);
    chk("t4_addr3", {24'd0, address}, 32'd3);
    steps(2);
    chk("t4_wrap_addr", {24'd0, address}, 32'd0);
    chk("t4_wrap_note", {24'd0, note_out}, 32'd3);
    chk("t4_wrap_valid", {31'd0, note_valid}, 32'd0);
    steps(2);
    chk("t4_note1", {24'd0, note_out}, 32'd1);
    steps(6);
    chk("t4_note2", {24'd0, note_out}, 32'd2);
    steps(1);
    restart = 1'b1;
    play    = 1'b0;
    steps(1);
    restart = 1'b0;
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_note", {24'd0, note_out}, 32'd0);
    chk("sb_drain_b", exp_q.size(), 32'd0);
    rom[3]  = 8'd4;
    loop_en = 1'b0;

    // Pause for 10 cycles during note 4
    play = 1'b1;
    push_seq(1, 5);
    steps(22);
    chk("t5_pre_note", {24'd0, note_out}, 32'd4);
    play = 1'b0;
    steps(1);
    chk("t5_pause_note", {24'd0, note_out}, 32'd0);
    chk("t5_pause_addr", {24'd0, address}, 32'd3);
    chk("t5_pause_busy", {31'd0, busy}, 32'd1);
    steps(9);
    chk("t5_late_note", {24'd0, note_out}, 32'd0);
    chk("t5_late_addr", {24'd0, address}, 32'd3);
    chk("t5_late_valid", {31'd0, note_valid}, 32'd0);
    play = 1'b1;
    steps(1);
    chk("t5_resume_note", {24'd0, note_out}, 32'd4);
    chk("t5_resume_addr", {24'd0, address}, 32'd3);
    steps(1);
    chk("t5_beat3_addr", {24'd0, address}, 32'd3);
    steps(1);
    chk("t5_next_addr", {24'd0, address}, 32'd4);
    steps(2);
    chk("t5_note5", {24'd0, note_out}, 32'd5);

    // Restart mid-PLAY of note 5 with play held
    steps(1);
    restart = 1'b1;
    exp_q.push_back(8'd1);
    steps(1);
    restart = 1'b0;
    chk("t6_addr", {24'd0, address}, 32'd0);
    chk("t6_note", {24'd0, note_out}, 32'd0);
    chk("t6_valid", {31'd0, note_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    steps(2);
    chk("t6_note1", {24'd0, note_out}, 32'd1);
    chk("t6_valid1", {31'd0, note_valid}, 32'd1);
    chk("sb_drain_c", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
